// File: rtl/iomem_pkg.sv
// Shared definitions for the picosoc iomem router: FSM states, region and
// slot-field constants.
package iomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [7:0]  IOMEM_REGION = 8'h03;
  localparam logic [3:0]  STATUS_SLOT  = 4'hF;

  localparam int unsigned REGION_MSB = 31;
  localparam int unsigned REGION_LSB = 24;
  localparam int unsigned SLOT_MSB   = 23;
  localparam int unsigned SLOT_LSB   = 20;

endpackage

// File: rtl/iomem_router.sv
// Address decoder, sequencer and stall watchdog for the picosoc iomem bus.
// Define IOMEM_TIMEOUT_EN to build the ACCESS watchdog; otherwise ACCESS waits forever.
module iomem_router
  import iomem_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    iomem_valid,
  input  logic [3:0]              iomem_wstrb,
  input  logic [31:0]             iomem_addr,
  input  logic [31:0]             iomem_wdata,
  output logic                    iomem_ready,
  output logic [31:0]             iomem_rdata,
  output logic [NUM_SLOTS-1:0]    slot_valid,
  input  logic [NUM_SLOTS-1:0]    slot_ready,
  output logic [19:0]             slot_addr,
  output logic [3:0]              slot_wstrb,
  output logic [31:0]             slot_wdata,
  input  logic [32*NUM_SLOTS-1:0] slot_rdata,
  output logic                    err_flag
);

  localparam int unsigned RD_W = $clog2(32*NUM_SLOTS);

  state_t      state, state_nxt;
  logic [3:0]  slot_idx;
  logic [3:0]  req_slot;
  logic [31:0] rdata_q, rdata_nxt;
  logic [15:0] err_count;
  logic        accept, sel_ready, timeout_hit;
  logic        rdata_ld, err_set, err_clr;
  logic [RD_W-1:0] rd_base;
  logic [31:0] sel_rdata;
  logic [31:0] status_word;

  assign req_slot    = iomem_addr[SLOT_MSB:SLOT_LSB];
  assign accept      = iomem_valid && !iomem_ready &&
                       (iomem_addr[REGION_MSB:REGION_LSB] == IOMEM_REGION);
  assign iomem_ready = (state == ST_RESP);
  assign iomem_rdata = rdata_q;
  assign status_word = {15'b0, err_flag, err_count};

  // Only meaningful in ACCESS, where slot_idx is always a mapped slot.
  assign rd_base   = RD_W'({slot_idx, 5'b0});
  assign sel_rdata = slot_rdata[rd_base +: 32];
  assign sel_ready = |(slot_ready & slot_valid);

  always_comb begin
    slot_valid = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      slot_valid[k] = (state == ST_ACCESS) && (slot_idx == 4'(k));
    end
  end

`ifdef IOMEM_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (state == ST_IDLE && accept) begin
      wait_cnt <= '0;
    end else if (state == ST_ACCESS) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Comparing against TIMEOUT-1 aborts at the edge where the count would reach TIMEOUT.
  assign timeout_hit = (wait_cnt == 16'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    rdata_ld  = 1'b0;
    rdata_nxt = rdata_q;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (32'(req_slot) < NUM_SLOTS) begin
            state_nxt = ST_ACCESS;
          end else if (req_slot == STATUS_SLOT) begin
            state_nxt = ST_RESP;
            rdata_ld  = 1'b1;
            rdata_nxt = status_word;
            err_clr   = |iomem_wstrb;
          end else begin
            state_nxt = ST_RESP;
            rdata_ld  = 1'b1;
            rdata_nxt = ERR_DATA;
            err_set   = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_nxt = ST_RESP;
          rdata_ld  = 1'b1;
          rdata_nxt = sel_rdata;
        end else if (timeout_hit) begin
          state_nxt = ST_RESP;
          rdata_ld  = 1'b1;
          rdata_nxt = ERR_DATA;
          err_set   = 1'b1;
        end
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      rdata_q    <= '0;
      slot_idx   <= '0;
      slot_addr  <= '0;
      slot_wstrb <= '0;
      slot_wdata <= '0;
      err_flag   <= 1'b0;
      err_count  <= '0;
    end else begin
      state <= state_nxt;
      if (rdata_ld) rdata_q <= rdata_nxt;
      if (state == ST_IDLE && accept) begin
        slot_idx   <= req_slot;
        slot_addr  <= iomem_addr[19:0];
        slot_wstrb <= iomem_wstrb;
        slot_wdata <= iomem_wdata;
      end
      if (err_clr) begin
        err_flag  <= 1'b0;
        err_count <= '0;
      end else if (err_set) begin
        err_flag <= 1'b1;
        if (err_count != '1) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_iomem_router.sv
// Directed bench for iomem_router: slot access, waits, unmapped, status,
// watchdog (build-dependent) and mid-access reset.
module tb_iomem_router;

  logic         clk = 1'b0;
  logic         resetn;
  logic         iomem_valid;
  logic [3:0]   iomem_wstrb;
  logic [31:0]  iomem_addr;
  logic [31:0]  iomem_wdata;
  logic         iomem_ready;
  logic [31:0]  iomem_rdata;
  logic [3:0]   slot_valid;
  logic [3:0]   slot_ready;
  logic [19:0]  slot_addr;
  logic [3:0]   slot_wstrb;
  logic [31:0]  slot_wdata;
  logic [127:0] slot_rdata;
  logic         err_flag;

  int checks   = 0;
  int failures = 0;

  iomem_router #(
    .NUM_SLOTS(4),
    .TIMEOUT  (255),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_ready(iomem_ready),
    .iomem_rdata(iomem_rdata),
    .slot_valid (slot_valid),
    .slot_ready (slot_ready),
    .slot_addr  (slot_addr),
    .slot_wstrb (slot_wstrb),
    .slot_wdata (slot_wdata),
    .slot_rdata (slot_rdata),
    .err_flag   (err_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // lat counts cycles after the acceptance edge until iomem_ready is seen (-1: never).
  task automatic access(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                        input logic [3:0] rdy, input int w, input logic [3:0] noise,
                        input int max_n, output int lat, output logic [31:0] rd,
                        output logic [3:0] sv_seen, output bit hold_bad);
    lat = -1; rd = 'x; sv_seen = '0; hold_bad = 1'b0;
    tick();
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd;
    for (int n = 1; n <= max_n; n++) begin
      tick();
      slot_ready = noise | ((n > w) ? rdy : 4'b0000);
      sv_seen |= slot_valid;
      if (slot_addr !== addr[19:0] || slot_wstrb !== strb || slot_wdata !== wd) hold_bad = 1'b1;
      if (iomem_ready) begin
        lat = n; rd = iomem_rdata;
        break;
      end
    end
    iomem_valid = 1'b0;
    slot_ready  = '0;
  endtask

  int          lat;
  logic [31:0] rd;
  logic [3:0]  sv;
  bit          hb;

  initial begin
    resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0; iomem_wdata = '0;
    slot_ready = '0;
    slot_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hCAFE_0000};
    repeat (3) tick();
    check("rst_ready", {31'b0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_slot_valid", {28'b0, slot_valid}, 32'd0);
    check("rst_err_flag", {31'b0, err_flag}, 32'd0);
    check("rst_latched", {slot_addr, slot_wstrb, 8'b0} | slot_wdata, 32'd0);
    resetn = 1'b1;

    // Zero-wait read of slot 1
    access(32'h0310_0004, 4'h0, 32'h0, 4'b0010, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("rd1_lat", lat, 32'd2);
    check("rd1_data", rd, 32'h1234_5678);
    check("rd1_addr", {12'b0, slot_addr}, 32'h0000_0004);
    check("rd1_sv", {28'b0, sv}, 32'h2);
    tick();
    check("rd1_ready_pulse", {31'b0, iomem_ready}, 32'd0);

    // Write slot 0 with three wait cycles
    access(32'h0300_0010, 4'b0001, 32'hA5, 4'b0001, 3, 4'b0000, 20, lat, rd, sv, hb);
    check("wr0_lat", lat, 32'd5);
    check("wr0_hold", {31'b0, hb}, 32'd0);
    check("wr0_sv", {28'b0, sv}, 32'h1);
    check("wr0_wdata", slot_wdata, 32'hA5);
    check("wr0_wstrb", {28'b0, slot_wstrb}, 32'h1);

    // Non-selected slots signalling ready are ignored
    access(32'h0320_0000, 4'h0, 32'h0, 4'b0100, 2, 4'b1011, 20, lat, rd, sv, hb);
    check("rd2_noise_lat", lat, 32'd4);
    check("rd2_noise_data", rd, 32'h2222_2222);

    // Unmapped slot 5
    access(32'h0350_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("unm_lat", lat, 32'd1);
    check("unm_data", rd, 32'hDEAD_BEEF);
    check("unm_err_flag", {31'b0, err_flag}, 32'd1);
    check("unm_sv", {28'b0, sv}, 32'd0);
    access(32'h03F0_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("stat1_lat", lat, 32'd1);
    check("stat1_data", rd, 32'h0001_0001);

    access(32'h0370_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("unm2_data", rd, 32'hDEAD_BEEF);
    access(32'h03F0_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("stat2_data", rd, 32'h0001_0002);

    // Status write clears, then read back
    access(32'h03F0_0000, 4'hF, 32'h0, 4'b0000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("statclr_lat", lat, 32'd1);
    access(32'h03F0_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("stat3_data", rd, 32'h0);
    check("statclr_err_flag", {31'b0, err_flag}, 32'd0);

    // Other region ignored
    access(32'h0200_0000, 4'h0, 32'h0, 4'b1111, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("region_lat", lat, 32'hFFFF_FFFF);
    check("region_sv", {28'b0, sv}, 32'd0);

    access(32'h03E0_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("unm3_data", rd, 32'hDEAD_BEEF);

`ifdef IOMEM_TIMEOUT_EN
    // Ready in the last allowed ACCESS cycle beats the watchdog
    access(32'h0330_0000, 4'h0, 32'h0, 4'b1000, 254, 4'b0000, 300, lat, rd, sv, hb);
    check("tie_lat", lat, 32'd256);
    check("tie_data", rd, 32'h3333_3333);
    access(32'h03F0_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("tie_status", rd, 32'h0001_0001);

    access(32'h0320_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 300, lat, rd, sv, hb);
    check("to_lat", lat, 32'd256);
    check("to_data", rd, 32'hDEAD_BEEF);
    check("to_err_flag", {31'b0, err_flag}, 32'd1);

    tick();
    iomem_valid = 1'b1; iomem_addr = 32'h0320_0000; iomem_wstrb = '0;
    repeat (3) tick();
    iomem_valid = 1'b0;
`else
    access(32'h0320_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 1000, lat, rd, sv, hb);
    check("nto_lat", lat, 32'hFFFF_FFFF);
`endif

    // Reset while in ACCESS
    check("pre_rst_sv", {28'b0, slot_valid}, 32'h4);
    check("pre_rst_err", {31'b0, err_flag}, 32'd1);
    resetn = 1'b0;
    tick();
    check("mid_rst_sv", {28'b0, slot_valid}, 32'd0);
    check("mid_rst_err", {31'b0, err_flag}, 32'd0);
    check("mid_rst_ready", {31'b0, iomem_ready}, 32'd0);
    resetn = 1'b1;

    // Recovery, back-to-back accesses
    access(32'h0310_0000, 4'h0, 32'h0, 4'b0010, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("b2b1_lat", lat, 32'd2);
    access(32'h0330_0008, 4'h0, 32'h0, 4'b1000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("b2b2_lat", lat, 32'd2);
    check("b2b2_data", rd, 32'h3333_3333);
    access(32'h03F0_0000, 4'h0, 32'h0, 4'b0000, 0, 4'b0000, 20, lat, rd, sv, hb);
    check("post_rst_status", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iomem_router.md
# iomem_router

Address decoder, sequencer and watchdog for the picosoc `iomem` bus. It sits between the SoC's single `iomem_*` port and up to `NUM_SLOTS` peripheral slots in the 0x03xx_xxxx region. It serialises one access at a time onto the addressed slot and returns the slot's read data. It terminates accesses that are unmapped or that stall, and exposes a sticky error flag suitable for `irq_5`.

## Interface
- `NUM_SLOTS`, 4: peripheral slots, 1..15; slot index = `iomem_addr[23:20]`.
- `TIMEOUT`, 255: ACCESS cycles allowed before watchdog abort, 1..65535.
- `ERR_DATA`, 32'hDEAD_BEEF: `iomem_rdata` returned on any error termination.
- Reset and clock: `resetn` is synchronous and active-low; the clock is `clk`.
- `clk` in 1: system clock.
- `resetn` in 1: synchronous, active-low reset.
- `iomem_valid` in 1: SoC request.
- `iomem_wstrb` in 4: byte write strobes; 0 means read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_ready` out 1: one-cycle completion pulse.
- `iomem_rdata` out 32: read data, valid while `iomem_ready`=1.
- `slot_valid` out NUM_SLOTS: one-hot request to slot.
- `slot_ready` in NUM_SLOTS: slot completion.
- `slot_addr` out 20: latched `iomem_addr[19:0]`.
- `slot_wstrb` out 4: latched strobes.
- `slot_wdata` out 32: latched write data.
- `slot_rdata` in 32*NUM_SLOTS: slot k occupies bits [32k+31:32k].
- `err_flag` out 1: sticky error indicator.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP. One access is outstanding at most.
- **IDLE**: the request is accepted when `iomem_valid && !iomem_ready && iomem_addr[31:24]==8'h03`.
  - Latch addr, wdata, wstrb and slot index.
  - Other regions are ignored. The router stays in IDLE and never drives `iomem_ready`.
- **Decode**: index s is resolved as follows.
  - s < NUM_SLOTS: go to ACCESS.
  - s == 15 (status slot): go to RESP with rdata = {15'b0, err_flag, err_count[15:0]}.
    - A status write with `wstrb`≠0 clears `err_flag` and `err_count`.
  - Any other s: unmapped. Go to RESP with `ERR_DATA`, set `err_flag`, and increment `err_count` (saturating at 16'hFFFF).
- **ACCESS**: `slot_valid[s]`=1 and the wait counter increments every cycle.
  - When `slot_ready[s]`=1, capture `slot_rdata[s]` and go to RESP.
  - When the watchdog expires, treat it as an error, same as unmapped.
  - If `slot_ready[s]` and expiry occur in the same cycle, `slot_ready` wins and no error is raised.
  - `slot_ready` of non-selected slots is ignored.
- **RESP**: `iomem_ready`=1 for exactly one cycle, `slot_valid`=0, then go to IDLE.
- `slot_addr`, `slot_wstrb` and `slot_wdata` hold their latched values from acceptance until the next acceptance.
- Reset values: state=IDLE; `iomem_ready`=0; `iomem_rdata`=0; `slot_valid`=0; latched fields=0; `err_flag`=0; `err_count`=0; wait counter=0.
- A reset asserted mid-ACCESS drops `slot_valid` on the next edge. No `iomem_ready` is issued.

## Timing
- Acceptance edge E0. `slot_valid` is high in the cycle after E0.
- With zero-wait `slot_ready` (combinational in that cycle), `iomem_ready` is high in the second cycle after E0. Minimum latency is 2 cycles.
- Status and unmapped accesses: `iomem_ready` is high in the cycle after E0.
- Timeout: abort when the wait counter reaches `TIMEOUT` with no `slot_ready`. `iomem_ready` follows one cycle later.
- Back-to-back accesses: acceptance is possible in the cycle after the RESP cycle.

## Configuration
- `IOMEM_TIMEOUT_EN`
  - Defined: watchdog active as above.
  - Undefined: no wait counter is synthesised and ACCESS waits indefinitely for `slot_ready`. Errors come only from unmapped slots, and the `TIMEOUT` parameter is ignored.

## Structure
- Shared package `iomem_pkg` holds:
  - state encoding constants;
  - `IOMEM_REGION` = 8'h03;
  - `STATUS_SLOT` = 4'hF;
  - the slot-field bit positions.
- Single module; no sub-module. The rdata mux is an indexed part-select inside.

## Test plan
- Read slot 1 at 0x0310_0004, with slot 1 ready in its first valid cycle and rdata 32'h1234_5678. Expect:
  - `slot_addr`=20'h0_0004;
  - `iomem_ready` 2 cycles after acceptance;
  - `iomem_rdata`=32'h1234_5678.
- Write 32'hA5 with wstrb 4'b0001 to slot 0, with 3 wait cycles. Expect:
  - `slot_wdata`=32'hA5 and `slot_wstrb`=1 held throughout;
  - `iomem_ready` 5 cycles after acceptance.
- Read 0x0350_0000 with NUM_SLOTS=4. Expect `iomem_rdata`=32'hDEAD_BEEF, `err_flag`=1 and `err_count`=1, with no `slot_valid`.
- Slot 2 never ready, TIMEOUT=255, `IOMEM_TIMEOUT_EN` defined. Expect the abort after 255 ACCESS cycles, `iomem_rdata`=32'hDEAD_BEEF and `err_flag`=1. Repeat with the macro undefined: no `iomem_ready` within 1000 cycles.
- Read 0x03F0_0000 after two errors: expect 32'h0001_0002. Write wstrb=4'hF to 0x03F0_0000, then read it: expect 0.
- Access 0x0200_0000: expect no `iomem_ready` and no `slot_valid`. Separately, assert `resetn`=0 mid-ACCESS: `slot_valid`=0 and `err_flag`=0 after the next edge.
